// File: rtl/conv_pkg.sv
// Shared types for the 3x3 convolution window controller.
//   PIX_W  : signed pixel width
//   COEF_W : signed kernel coefficient width
//   ACC_W  : signed width of one convolution sum from the MAC datapath
package conv_pkg;

  localparam int PIX_W  = 9;
  localparam int COEF_W = 8;
  localparam int ACC_W  = 17;

  typedef logic signed [PIX_W-1:0]  pix_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  // [row][col], [0][0] is the top-left (oldest) tap, [2][2] the newest pixel.
  typedef pix_t  [0:2][0:2] win_pix_t;
  typedef coef_t [0:2][0:2] win_fil_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of delay: a DEPTH-deep shift register of pixels.
// The output is the oldest entry, read before the shift, so on every
// accepted pixel dout_o is the pixel from the same column one row earlier.
//   clk     : clock
//   shift_i : shift din_i in (one accepted pixel)
//   din_i   : pixel entering the row delay
//   dout_o  : pixel leaving the row delay
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic shift_i,
  input  pix_t din_i,
  output pix_t dout_o
);

  pix_t mem_q [DEPTH];

  assign dout_o = mem_q[DEPTH-1];

  // NOTE: storage arrays carry no reset; every entry is rewritten before a
  // window can consume it, and a reset here would only cost flop area.
  always_ff @(posedge clk) begin
    if (shift_i) begin
      mem_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// Sequencer for a 3x3 valid-only convolution over a raster pixel stream.
// Builds windows from two line buffers plus a 3x3 shift register, hands them
// to an external MAC datapath, and queues the returned sums in a FWFT FIFO.
//   clk, rst              : clock, synchronous active-high reset
//   start, fil_in         : frame start (IDLE only) and kernel latched with it
//   pix_in/valid/ready    : raster pixel stream handshake
//   win_pix/fil/valid     : window, kernel and 1-cycle strobe to the datapath
//   dp_result             : datapath sum, one cycle after win_valid
//   res_out/valid/ready   : result stream handshake
//   busy, done            : not IDLE; one-cycle frame-end pulse
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int OFIFO_D = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     start,
  input  win_fil_t fil_in,
  input  pix_t     pix_in,
  input  logic     pix_valid,
  output logic     pix_ready,
  output win_pix_t win_pix,
  output win_fil_t win_fil,
  output logic     win_valid,
  input  acc_t     dp_result,
  output acc_t     res_out,
  output logic     res_valid,
  input  logic     res_ready,
  output logic     busy,
  output logic     done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int PTR_W = $clog2(OFIFO_D);
  localparam int CNT_W = $clog2(OFIFO_D + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OFIFO_D - 1);

  state_e             state_q, state_d;
  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   row_q;
  win_pix_t           win_q;
  win_fil_t           fil_q;
  logic               win_valid_q, dp_valid_q;
  pix_t               lb0_out, lb1_out;
  acc_t               fifo_mem [OFIFO_D];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [SUM_W-1:0]   pending;
  logic               room, accept, last_col, produce, push, pop;

  // Every window already accepted but not yet popped is counted, so a pixel
  // is only taken when its eventual result is guaranteed a FIFO slot.
  assign pending  = SUM_W'(count_q) + SUM_W'(win_valid_q) + SUM_W'(dp_valid_q);
  assign room     = pending < SUM_W'(OFIFO_D);
  assign accept   = pix_valid && pix_ready;
  assign last_col = (col_q == COL_LAST);
  assign produce  = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
  assign push     = dp_valid_q;
  assign pop      = res_valid && res_ready;

  conv_line_buffer #(.DEPTH(IMG_W)) u_lb_r1 (
    .clk     (clk),
    .shift_i (accept),
    .din_i   (pix_in),
    .dout_o  (lb0_out)
  );

  conv_line_buffer #(.DEPTH(IMG_W)) u_lb_r2 (
    .clk     (clk),
    .shift_i (accept),
    .din_i   (lb0_out),
    .dout_o  (lb1_out)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    pix_ready = 1'b0;
    busy      = (state_q != ST_IDLE);
    done      = 1'b0;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FILL;
      ST_FILL: begin
        pix_ready = room;
        if (pix_valid && room && row_q == ROW_W'(1) && last_col) state_d = ST_RUN;
      end
      ST_RUN: begin
        pix_ready = room;
        if (pix_valid && room && row_q == ROW_LAST && last_col) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (pending == '0) state_d = ST_DONE;
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      fil_q       <= '0;
      win_valid_q <= 1'b0;
      dp_valid_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == ST_IDLE && start) begin
        fil_q <= fil_in;
        col_q <= '0;
        row_q <= '0;
      end else if (accept) begin
        if (last_col) begin
          col_q <= '0;
          if (row_q != ROW_LAST) row_q <= row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end

      // Columns slide left; the new right-hand column is rows r-2, r-1, r.
      if (accept) begin
        for (int i = 0; i < 3; i++) begin
          win_q[i][0] <= win_q[i][1];
          win_q[i][1] <= win_q[i][2];
        end
        win_q[0][2] <= lb1_out;
        win_q[1][2] <= lb0_out;
        win_q[2][2] <= pix_in;
      end

      win_valid_q <= produce;
      dp_valid_q  <= win_valid_q;

      if (push) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= dp_result;
  end

  assign res_valid = (count_q != '0);
  // Gated so the unreset storage never shows on the port while empty.
  assign res_out   = res_valid ? fifo_mem[rd_ptr_q] : '0;
  assign win_pix   = win_q;
  assign win_fil   = fil_q;
  assign win_valid = win_valid_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
module tb_conv_window_ctrl;
  import conv_pkg::*;

  typedef acc_t [0:8] exp_t;
  typedef struct {
    bit       sel;      // 0: 4x4 instance, 1: 5x5 instance
    win_fil_t fil;
    int       base;
    int       stp;      // pixel k = base + stp*k
    bit       stall;    // hold res_ready low 20 cycles from pixel stall_k
    int       stall_k;
    bit       poke;     // pulse start mid-frame and in DONE
    int       n_exp;
    exp_t     exp_res;
    int       drop_k;   // first pixel index refused in FILL/RUN, -1 none
  } vec_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, pix_valid = 1'b0, res_ready = 1'b1;
  logic sel = 1'b0;
  win_fil_t fil_in = '0;
  pix_t     pix_in = '0;

  logic pr4, wv4, rv4, bz4, dn4, pr5, wv5, rv5, bz5, dn5;
  win_pix_t wp4, wp5;
  win_fil_t wf4, wf5;
  acc_t ro4, ro5;
  acc_t dp4 = '0, dp5 = '0;

  logic pix_ready_m, win_valid_m, res_valid_m, busy_m, done_m;
  win_pix_t win_pix_m;
  win_fil_t win_fil_m;
  acc_t res_out_m;

  conv_window_ctrl #(.IMG_W(4), .IMG_H(4), .OFIFO_D(4)) dut4 (
    .clk(clk), .rst(rst), .start(start && !sel), .fil_in(fil_in), .pix_in(pix_in),
    .pix_valid(pix_valid && !sel), .pix_ready(pr4), .win_pix(wp4), .win_fil(wf4),
    .win_valid(wv4), .dp_result(dp4), .res_out(ro4), .res_valid(rv4),
    .res_ready(res_ready), .busy(bz4), .done(dn4));

  conv_window_ctrl #(.IMG_W(5), .IMG_H(5), .OFIFO_D(4)) dut5 (
    .clk(clk), .rst(rst), .start(start && sel), .fil_in(fil_in), .pix_in(pix_in),
    .pix_valid(pix_valid && sel), .pix_ready(pr5), .win_pix(wp5), .win_fil(wf5),
    .win_valid(wv5), .dp_result(dp5), .res_out(ro5), .res_valid(rv5),
    .res_ready(res_ready), .busy(bz5), .done(dn5));

  assign pix_ready_m = sel ? pr5 : pr4;
  assign win_valid_m = sel ? wv5 : wv4;
  assign res_valid_m = sel ? rv5 : rv4;
  assign busy_m      = sel ? bz5 : bz4;
  assign done_m      = sel ? dn5 : dn4;
  assign win_pix_m   = sel ? wp5 : wp4;
  assign win_fil_m   = sel ? wf5 : wf4;
  assign res_out_m   = sel ? ro5 : ro4;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External MAC datapath stand-in: sum registered one cycle after its window.
  function automatic acc_t mac(input win_pix_t w, input win_fil_t f);
    acc_t s = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s = s + acc_t'($signed(w[i][j]) * $signed(f[i][j]));
    return s;
  endfunction

  always @(posedge clk) begin
    if (wv4) dp4 <= mac(wp4, wf4);
    if (wv5) dp5 <= mac(wp5, wf5);
  end

  acc_t got[$];
  int first_res = -1, last_res = -1, done_cnt = 0, done_cyc = -1;
  always @(negedge clk) begin
    if (res_valid_m && res_ready) begin
      got.push_back(res_out_m);
      if (first_res < 0) first_res = cyc;
      last_res = cyc;
    end
    if (done_m) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  int checks = 0, errors = 0;
  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  int tt = 0, stall_t = -1;
  task automatic tick();
    @(posedge clk);
    #1;
    tt++;
    res_ready = !(stall_t >= 0 && (tt - stall_t) < 20);
  endtask

  function automatic win_fil_t uni(input int v);
    win_fil_t f;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) f[i][j] = coef_t'(v);
    return f;
  endfunction

  function automatic win_fil_t one_at(input int r, input int c);
    win_fil_t f = '0;
    f[r][c] = coef_t'(1);
    return f;
  endfunction

  function automatic win_fil_t sharpen();
    win_fil_t f = '0;
    f[1][1] = coef_t'(5);
    f[0][1] = coef_t'(-1);
    f[1][0] = coef_t'(-1);
    f[1][2] = coef_t'(-1);
    f[2][1] = coef_t'(-1);
    return f;
  endfunction

  function automatic exp_t ex4(input int a, input int b, input int c, input int d);
    exp_t e = '0;
    e[0] = acc_t'(a); e[1] = acc_t'(b); e[2] = acc_t'(c); e[3] = acc_t'(d);
    return e;
  endfunction

  function automatic exp_t exall(input int v);
    exp_t e;
    for (int i = 0; i < 9; i++) e[i] = acc_t'(v);
    return e;
  endfunction

  function automatic vec_t mk(input bit s, input win_fil_t f, input int b, input int st,
                              input bit stl, input int stk, input bit pk, input int n,
                              input exp_t e, input int dk);
    vec_t v;
    v.sel = s; v.fil = f; v.base = b; v.stp = st; v.stall = stl; v.stall_k = stk;
    v.poke = pk; v.n_exp = n; v.exp_res = e; v.drop_k = dk;
    return v;
  endfunction

  vec_t vecs[7];

  task automatic run_vec(input int vi);
    vec_t v = vecs[vi];
    int w = v.sel ? 5 : 4;
    int n = w * w;
    int prod = 2 * w + 2;
    int k = 0, t = 0, drop = -1, acc_cyc = -1;
    string p = $sformatf("v%0d", vi);
    sel = v.sel;
    got.delete();
    first_res = -1; last_res = -1; done_cnt = 0; done_cyc = -1; stall_t = -1;
    fil_in = v.fil;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (k < n && t < 1000) begin
      if (v.stall && stall_t < 0 && k == v.stall_k) begin
        stall_t = tt;
        res_ready = 1'b0;
      end
      if (v.poke && k == 5) begin
        start  = 1'b1;
        fil_in = uni(1);
      end else begin
        start = 1'b0;
      end
      pix_valid = 1'b1;
      pix_in = pix_t'(v.base + v.stp * k);
      if (pix_ready_m) begin
        if (k == prod) acc_cyc = cyc;
        k++;
      end else if (drop < 0) begin
        drop = k;
      end
      tick();
      t++;
    end
    pix_valid = 1'b0;
    start = 1'b0;
    check({p, "_pixels_taken"}, k, n);
    if (!v.stall) check({p, "_throughput_cycles"}, t, n);
    check({p, "_first_refused_pixel"}, drop, v.drop_k);
    t = 0;
    while (!done_m && t < 300) begin
      tick();
      t++;
    end
    check({p, "_done_reached"}, done_m, 1);
    if (v.poke) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      check({p, "_start_in_done_busy"}, busy_m, 0);
    end
    repeat (3) tick();
    check({p, "_done_pulses"}, done_cnt, 1);
    check({p, "_result_count"}, got.size(), v.n_exp);
    for (int i = 0; i < v.n_exp; i++)
      check($sformatf("%s_res%0d", p, i), (i < got.size()) ? longint'(got[i]) : -999999,
            longint'(v.exp_res[i]));
    if (!v.stall) check({p, "_accept_to_res_latency"}, first_res - acc_cyc, 3);
    check({p, "_done_after_last_res"}, (done_cyc - last_res >= 1) && (done_cyc - last_res <= 2), 1);
    stall_t = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, t, spurious;
    vecs[0] = mk(0, uni(1),       1,    1, 0, 0, 0, 4, ex4(54, 63, 90, 99), -1);
    vecs[1] = mk(0, uni(1),       1,    1, 1, 8, 0, 4, ex4(54, 63, 90, 99), -1);
    vecs[2] = mk(0, uni(-1),   -256,    0, 0, 0, 1, 4, exall(2304),         -1);
    vecs[3] = mk(0, one_at(0, 0), 1,    1, 0, 0, 0, 4, ex4(1, 2, 5, 6),     -1);
    vecs[4] = mk(0, one_at(2, 2), 1,    1, 0, 0, 0, 4, ex4(11, 12, 15, 16), -1);
    vecs[5] = mk(1, sharpen(),   10,    0, 0, 0, 0, 9, exall(10),           -1);
    vecs[6] = mk(1, sharpen(),   10,    0, 1, 5, 0, 9, exall(10),           18);

    repeat (3) tick();
    check("rst_busy", busy_m, 0);
    check("rst_done", done_m, 0);
    check("rst_pix_ready", pix_ready_m, 0);
    check("rst_res_valid", res_valid_m, 0);
    check("rst_win_valid", win_valid_m, 0);
    check("rst_res_out", res_out_m, 0);
    rst = 1'b0;
    tick();
    check("idle_pix_ready", pix_ready_m, 0);

    for (int vi = 0; vi < 7; vi++) begin
      run_vec(vi);
      repeat (2) tick();
    end

    // Reset in the cycle after the 10th pixel of a 4x4 frame.
    sel = 1'b0;
    fil_in = uni(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    t = 0;
    while (k < 10 && t < 100) begin
      pix_valid = 1'b1;
      pix_in = pix_t'(k + 1);
      if (pix_ready_m) k++;
      tick();
      t++;
    end
    check("midrst_pixels_taken", k, 10);
    rst = 1'b1;
    pix_in = pix_t'(11);
    tick();
    check("midrst_busy", busy_m, 0);
    check("midrst_done", done_m, 0);
    check("midrst_pix_ready", pix_ready_m, 0);
    check("midrst_win_valid", win_valid_m, 0);
    check("midrst_res_valid", res_valid_m, 0);
    check("midrst_res_out", res_out_m, 0);
    check("midrst_win_pix_zero", win_pix_m == '0, 1);
    check("midrst_win_fil_zero", win_fil_m == '0, 1);
    rst = 1'b0;
    pix_valid = 1'b0;
    spurious = 0;
    repeat (10) begin
      tick();
      if (res_valid_m || busy_m || win_valid_m) spurious++;
    end
    check("midrst_quiet_cycles", spurious, 0);
    run_vec(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_ctrl.md
CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- IMG_W, 8, image width in pixels, minimum 3.
- IMG_H, 8, image height in rows, minimum 3.
- OFIFO_D, 4, result FIFO depth, minimum 2.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on its rising edge.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, frame start; honoured only in IDLE.
- fil_in, in, 9x8 signed, kernel [0:2][0:2]; sampled on accepted start.
- pix_in, in, 9 signed, raster-order pixel.
- pix_valid, in, 1, pix_in is valid.
- pix_ready, out, 1, controller accepts the pixel this cycle.
- win_pix, out, 9x9 signed, window [0:2][0:2] to the MAC datapath.
- win_fil, out, 9x8 signed, latched kernel to the datapath.
- win_valid, out, 1, win_pix holds a new valid window.
- dp_result, in, 17 signed, datapath sum, registered 1 cycle after its window.
- res_out, out, 17 signed, convolution result.
- res_valid, out, 1, res_out is valid.
- res_ready, in, 1, consumer accepts res_out.
- busy, out, 1, high whenever state is not IDLE.
- done, out, 1, one-cycle pulse at frame end.

Function
REQ-003 FSM states SHALL be IDLE, FILL, RUN, DRAIN, DONE.
REQ-004 Transitions SHALL be:
- IDLE->FILL on start; this also latches fil_in and clears row/col counters.
- FILL->RUN on accepting the last pixel of row 1.
- RUN->DRAIN on accepting pixel (IMG_H-1, IMG_W-1).
- DRAIN->DONE when in-flight count = 0 and the FIFO is empty.
- DONE->IDLE unconditionally after 1 cycle.
REQ-005 start SHALL be ignored outside IDLE; start in DONE SHALL be ignored.
REQ-006 A pixel SHALL be accepted only when pix_valid && pix_ready.
REQ-007 pix_ready SHALL be 0 in IDLE, DRAIN and DONE.
REQ-008 In FILL and RUN, pix_ready SHALL equal (fifo_count + inflight) < OFIFO_D, where inflight counts windows in the win_valid stage and the datapath stage (0..2).
REQ-009 col SHALL wrap from IMG_W-1 to 0 and increment row; no row increments past IMG_H-1.
REQ-010 Two line buffers SHALL hold rows r-1 and r-2; a 3x3 shift register SHALL form the window from the line-buffer outputs plus pix_in.
REQ-011 Only fully interior windows SHALL be produced (no padding): a window is produced when the accepted pixel has row>=2 and col>=2; each frame yields exactly (IMG_W-2)*(IMG_H-2) windows.
REQ-012 win_valid SHALL be a 1-cycle pulse in the cycle after the producing accept; win_pix is stable while win_valid is high.
REQ-013 The dp_result sampled in the cycle after win_valid SHALL be written to the FIFO unmodified (17-bit, no saturation or rounding).
REQ-014 Accept-to-res_valid latency SHALL be 3 cycles when the FIFO is empty and res_ready is high.
REQ-015 Throughput SHALL be 1 pixel per cycle while res_ready is held high.
REQ-016 The FIFO SHALL present first-word-fall-through; a pop occurs on res_valid && res_ready.
REQ-017 A push and a pop in the same cycle SHALL both occur with the count unchanged, including when the FIFO is full.
REQ-018 FIFO overflow SHALL be impossible by construction of REQ-008.
REQ-019 done SHALL be high only in DONE; busy SHALL be 0 only in IDLE.
REQ-020 Results SHALL leave in raster order of window centre.

Reset
REQ-021 rst SHALL synchronously force:
- state to IDLE;
- row, col, FIFO pointers and count, inflight, win_valid, res_valid, done, busy and pix_ready to 0;
- res_out, win_pix and win_fil to 0.
REQ-022 Reset mid-frame SHALL discard partial windows and queued results; no res_valid is emitted before a new start.
REQ-023 Line-buffer contents SHALL need no reset, since no window uses them before refill.

Structure
REQ-024 Package conv_pkg SHALL hold:
- PIX_W=9, COEF_W=8, ACC_W=17;
- the pixel, coefficient and window typedefs;
- the FSM state enum.
REQ-025 One sub-module, conv_line_buffer (IMG_W deep, PIX_W wide, read-before-write shift), SHALL be instantiated twice.
REQ-026 The MAC datapath SHALL stay external; this block only sequences it.

Verification
REQ-027 4x4 frame, pixels 1..16, kernel all 1, res_ready=1 -> res_out 54, 63, 90, 99, then done 1 cycle later; exactly 4 results.
REQ-028 5x5 frame of constant 10, sharpen kernel (centre 5, edge -1, corners 0) -> 9 results all equal to 10.
REQ-029 Repeat REQ-027 with res_ready low for 20 cycles mid-frame -> pix_ready drops once 4 are pending/in-flight; same 4 values, no loss or duplicate.
REQ-030 Assert rst in the cycle after accepting pixel 10 of a 4x4 frame -> all outputs 0 next cycle; a new start yields correct results with no stale data.
REQ-031 Drive start while busy, and a negative kernel (all -1) with pixels -256 -> start ignored; each result = 2304, no truncation.
